// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-line refill from ROM.
module icache_dm #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req_i,
    input  logic [31:0]              if_addr_i,
    input  logic                     if_jump_i,
    input  logic                     icache_inv_i,
    output logic                     icache_hit_o,
    output logic                     icache_ready_o,
    output logic [31:0]              icache_inst_o,
    output logic                     rom_req_o,
    output logic [31:0]              rom_addr_o,
    input  logic                     rom_ready_i,
    input  logic [32*LINE_WORDS-1:0] rom_data_i
);
    localparam int WB  = $clog2(LINE_WORDS);
    localparam int OFF = WB + 2;
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TAG = 32 - IDX - OFF;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [NUM_LINES-1:0]   valid;
    logic [TAG-1:0]         tags [NUM_LINES];
    logic [31:0]            data [NUM_LINES][LINE_WORDS];
    logic [31:0]            miss_addr;
    logic                   drop, inv_pend;
    logic [IDX-1:0]         idx, midx;
    logic [TAG-1:0]         tag;
    logic [WB-1:0]          wsel, mwsel;
    logic                   hit_raw, fill_done, drain_done;

    assign idx        = if_addr_i[OFF +: IDX];
    assign tag        = if_addr_i[31 -: TAG];
    assign wsel       = if_addr_i[2 +: WB];
    assign midx       = miss_addr[OFF +: IDX];
    assign mwsel      = miss_addr[2 +: WB];
    assign hit_raw    = if_req_i && valid[idx] && tags[idx] == tag;
    assign fill_done  = state == FILL && rom_ready_i;
    assign drain_done = state == DRAIN && !rom_ready_i;

    always_comb begin
        state_nxt      = state;
        icache_hit_o   = 1'b0;
        icache_ready_o = 1'b0;
        icache_inst_o  = '0;
        rom_req_o      = 1'b0;
        rom_addr_o     = '0;
        case (state)
            IDLE: begin
                icache_hit_o = hit_raw;
                if (hit_raw) begin
                    icache_ready_o = 1'b1;
                    icache_inst_o  = data[idx][wsel];
                end else if (if_req_i) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                rom_req_o  = 1'b1;
                rom_addr_o = {miss_addr[31:OFF], {OFF{1'b0}}};
                if (rom_ready_i) begin
                    state_nxt = DRAIN;
                    // a redirect in the completion cycle suppresses delivery just like an earlier one
                    if (!drop && !if_jump_i) begin
                        icache_ready_o = 1'b1;
                        icache_inst_o  = rom_data_i[{mwsel, 5'b0} +: 32];
                    end
                end
            end
            DRAIN: state_nxt = rom_ready_i ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
            drop      <= 1'b0;
            inv_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && if_req_i && !hit_raw) begin
                miss_addr <= if_addr_i;
                drop      <= 1'b0;
            end
            if (state == FILL && if_jump_i)
                drop <= 1'b1;
            if (state != IDLE && icache_inv_i)
                inv_pend <= 1'b1;
            if (drain_done)
                inv_pend <= 1'b0;
            if (fill_done)
                valid[midx] <= 1'b1;
            if ((state == IDLE && icache_inv_i) || (drain_done && (inv_pend || icache_inv_i)))
                valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[midx] <= miss_addr[31 -: TAG];
            for (int i = 0; i < LINE_WORDS; i++)
                data[midx][i] <= rom_data_i[32*i +: 32];
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: random and directed checks of icache_dm against a line-residency model and a fixed ROM image.
module tb_icache_dm;
    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
    logic        req = 1'b0, jump = 1'b0, inv = 1'b0, rom_rdy = 1'b0;
    logic [31:0] addr = '0;
    int          tests = 0, fails = 0;

    logic        a_hit, a_rdy, a_rreq, b_hit, b_rdy, b_rreq;
    logic [31:0] a_inst, a_raddr, b_inst, b_raddr;
    logic [127:0] a_rdata;
    logic [255:0] b_rdata;
    logic        hit, rdy, rreq;
    logic [31:0] inst, raddr;

    // model: per DUT and index, whether a line is resident and which line number
    logic        mv [2][16];
    logic [31:0] ml [2][16];

    always #5 clk = ~clk;

    icache_dm u_a (
        .clk(clk), .rst_n(rst_n), .if_req_i(req & ~sel), .if_addr_i(addr),
        .if_jump_i(jump & ~sel), .icache_inv_i(inv & ~sel), .icache_hit_o(a_hit),
        .icache_ready_o(a_rdy), .icache_inst_o(a_inst), .rom_req_o(a_rreq),
        .rom_addr_o(a_raddr), .rom_ready_i(rom_rdy & ~sel), .rom_data_i(a_rdata)
    );

    icache_dm #(.NUM_LINES(4), .LINE_WORDS(8)) u_b (
        .clk(clk), .rst_n(rst_n), .if_req_i(req & sel), .if_addr_i(addr),
        .if_jump_i(jump & sel), .icache_inv_i(inv & sel), .icache_hit_o(b_hit),
        .icache_ready_o(b_rdy), .icache_inst_o(b_inst), .rom_req_o(b_rreq),
        .rom_addr_o(b_raddr), .rom_ready_i(rom_rdy & sel), .rom_data_i(b_rdata)
    );

    assign hit   = sel ? b_hit   : a_hit;
    assign rdy   = sel ? b_rdy   : a_rdy;
    assign inst  = sel ? b_inst  : a_inst;
    assign rreq  = sel ? b_rreq  : a_rreq;
    assign raddr = sel ? b_raddr : a_raddr;

    function automatic logic [31:0] romw(input logic [31:0] x);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb begin
        a_rdata = '0;
        b_rdata = '0;
        for (int k = 0; k < 4; k++) a_rdata[32*k +: 32] = romw(a_raddr + 32'(4*k));
        for (int k = 0; k < 8; k++) b_rdata[32*k +: 32] = romw(b_raddr + 32'(4*k));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) mv[sel][k] = 1'b0;
    endtask

    task automatic idle();
        tick();
        req = 1'b0; jump = 1'b0; inv = 1'b0; rom_rdy = 1'b0;
        @(negedge clk);
        chk("idle_hit", 32'(hit), 32'd0);
        chk("idle_ready", 32'(rdy), 32'd0);
    endtask

    // one fetch; inv_at: 0 = lookup cycle, k>=1 = FILL cycle k; jump_at: FILL cycle of redirect
    task automatic fetch(input logic [31:0] a, input int lat, input int jump_at, input int inv_at, input int hold);
        int          off, nl, i;
        logic [31:0] line, w;
        logic        exp_hit, dropped;
        off = sel ? 5 : 4;
        nl  = sel ? 4 : 16;
        line = a >> off;
        i = int'(line % 32'(nl));
        w = romw(a & ~32'd3);
        exp_hit = mv[sel][i] && ml[sel][i] == line;
        tick();
        req = 1'b1; addr = a; jump = 1'($urandom_range(0, 1)); inv = (inv_at == 0); rom_rdy = 1'b0;
        @(negedge clk);
        chk("lookup_hit", 32'(hit), 32'(exp_hit));
        chk("lookup_ready", 32'(rdy), 32'(exp_hit));
        chk("lookup_inst", inst, exp_hit ? w : 32'd0);
        chk("lookup_romreq", 32'(rreq), 32'd0);
        if (inv_at == 0) clear_model();
        if (!exp_hit) begin
            dropped = 1'b0;
            for (int j = 1; j <= lat + 1; j++) begin
                tick();
                jump = (j == jump_at); inv = (j == inv_at); rom_rdy = (j == lat + 1);
                if (jump) dropped = 1'b1;
                @(negedge clk);
                chk("fill_romreq", 32'(rreq), 32'd1);
                chk("fill_romaddr", raddr, line << off);
                chk("fill_hit", 32'(hit), 32'd0);
                chk(j <= lat ? "fill_ready" : "done_ready", 32'(rdy), 32'(j == lat + 1 && !dropped));
                chk(j <= lat ? "fill_inst" : "done_inst", inst, (j == lat + 1 && !dropped) ? w : 32'd0);
            end
            mv[sel][i] = 1'b1;
            ml[sel][i] = line;
            for (int d = 0; d <= hold; d++) begin
                tick();
                jump = 1'b0; inv = 1'b0; rom_rdy = (d < hold);
                @(negedge clk);
                chk("drain_romreq", 32'(rreq), 32'd0);
                chk("drain_ready", 32'(rdy), 32'd0);
                chk("drain_hit", 32'(hit), 32'd0);
            end
            if (inv_at >= 1 && inv_at <= lat + 1) clear_model();
        end
    endtask

    task automatic rnd_fetch();
        int lat, ja, ia;
        logic [31:0] a;
        lat = $urandom_range(0, 4);
        a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
        ja = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat + 1) : -1;
        ia = ($urandom_range(0, 11) == 0) ? $urandom_range(0, lat + 1) : -1;
        fetch(a, lat, ja, ia, $urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) idle();
    endtask

    initial begin
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 16; k++) begin mv[s][k] = 1'b0; ml[s][k] = '0; end
        #2;
        chk("rst_a_hit", 32'(a_hit), 32'd0);
        chk("rst_a_ready", 32'(a_rdy), 32'd0);
        chk("rst_a_inst", a_inst, 32'd0);
        chk("rst_a_romreq", 32'(a_rreq), 32'd0);
        chk("rst_a_romaddr", a_raddr, 32'd0);
        chk("rst_b_romreq", 32'(b_rreq), 32'd0);
        chk("rst_b_romaddr", b_raddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        // cold miss, then same-line hit
        fetch(32'h08, 3, -1, -1, 0);
        fetch(32'h0C, 3, -1, -1, 0);
        // conflict on index 0
        fetch(32'h000, 2, -1, -1, 1);
        fetch(32'h100, 2, -1, -1, 0);
        fetch(32'h000, 1, -1, -1, 0);
        // redirect in second FILL cycle drops delivery, line still written
        fetch(32'h40, 3, 2, -1, 0);
        fetch(32'h44, 3, -1, -1, 0);
        // invalidate during FILL clears the new line on return to IDLE
        fetch(32'h80, 2, -1, 1, 1);
        fetch(32'h80, 2, -1, -1, 0);
        // invalidate in IDLE alongside a hit: hit uses pre-clear state
        fetch(32'h84, 0, -1, 0, 0);
        fetch(32'h84, 0, -1, -1, 0);
        // reset during FILL
        tick();
        req = 1'b1; addr = 32'h300; jump = 1'b0; inv = 1'b0; rom_rdy = 1'b0;
        @(negedge clk);
        chk("rstfill_lookup_hit", 32'(hit), 32'd0);
        tick();
        @(negedge clk);
        chk("rstfill_romreq_before", 32'(rreq), 32'd1);
        rom_rdy = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rstfill_romreq_after", 32'(rreq), 32'd0);
        chk("rstfill_ready_after", 32'(rdy), 32'd0);
        chk("rstfill_romaddr_after", raddr, 32'd0);
        clear_model();
        sel = 1'b1; clear_model(); sel = 1'b0;
        rom_rdy = 1'b0; req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h300, 1, -1, -1, 0);
        for (int n = 0; n < 150; n++) rnd_fetch();
        // second geometry: 4 lines of 8 words
        idle();
        sel = 1'b1;
        fetch(32'h00, 2, -1, -1, 0);
        fetch(32'h80, 2, -1, -1, 0);
        fetch(32'h00, 1, -1, -1, 0);
        fetch(32'h1C, 1, -1, -1, 0);
        for (int n = 0; n < 60; n++) rnd_fetch();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
